dmem_arbiter: RTL and testbench

- Shares the single-port 32x8 data memory between two requesters: requester 0 is the CPU load/store path, requester 1 is the host/debug loader port.
- Serialises accesses through a small FSM.
- Grants on a round-robin basis.
- Returns read data and a one-cycle done pulse to the requester that was served.

---
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port 32x8 data memory between the CPU (0) and host loader (1).
// Optional locked-burst support is compiled in with DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  w_r0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  lock0,
  output logic                  gnt0,
  output logic                  done0,
  input  logic                  req1,
  input  logic                  w_r1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_w_r,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  w_r;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  state_t                state, state_nxt;
  logic                  last_grant, last_nxt;
  logic                  cur, cur_nxt;
  logic                  gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, busy_nxt;
  logic                  mem_en_nxt, mem_w_r_nxt;
  logic [ADDR_BITS-1:0]  mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt, rdata_nxt;
  logic                  pick_c;
  acc_t                  acc0_c, acc1_c, sel_acc_c;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned LOCK_MAX = 4;
  localparam int unsigned LCNT_W   = 3;
  logic [LCNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic              relock_c;
  acc_t              cur_acc_c;
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif

  assign acc0_c = {w_r0, addr0, wdata0};
  assign acc1_c = {w_r1, addr1, wdata1};
  // On a tie the requester that was not served last wins
  assign pick_c    = (req0 & req1) ? ~last_grant : req1;
  assign sel_acc_c = pick_c ? acc1_c : acc0_c;

`ifdef DMEM_ARB_LOCK_EN
  assign cur_acc_c = cur ? acc1_c : acc0_c;
  assign relock_c  = (cur ? (lock1 & req1) : (lock0 & req0)) && (lock_cnt < LCNT_W'(LOCK_MAX));
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    last_nxt      = last_grant;
    cur_nxt       = cur;
    gnt0_nxt      = 1'b0;
    gnt1_nxt      = 1'b0;
    done0_nxt     = 1'b0;
    done1_nxt     = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_w_r_nxt   = mem_w_r;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rdata_nxt     = rdata;
`ifdef DMEM_ARB_LOCK_EN
    lock_cnt_nxt  = lock_cnt;
`endif
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt     = ACCESS;
          last_nxt      = pick_c;
          cur_nxt       = pick_c;
          gnt0_nxt      = ~pick_c;
          gnt1_nxt      = pick_c;
          mem_en_nxt    = 1'b1;
          mem_w_r_nxt   = sel_acc_c.w_r;
          mem_addr_nxt  = sel_acc_c.addr;
          mem_wdata_nxt = sel_acc_c.wdata;
`ifdef DMEM_ARB_LOCK_EN
          lock_cnt_nxt  = LCNT_W'(1);
`endif
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        state_nxt = IDLE;
        if (!mem_w_r) rdata_nxt = mem_rdata;
        done0_nxt = ~cur;
        done1_nxt = cur;
`ifdef DMEM_ARB_LOCK_EN
        // Locked burst: reissue straight to ACCESS, skipping arbitration
        if (relock_c) begin
          state_nxt     = ACCESS;
          gnt0_nxt      = ~cur;
          gnt1_nxt      = cur;
          mem_en_nxt    = 1'b1;
          mem_w_r_nxt   = cur_acc_c.w_r;
          mem_addr_nxt  = cur_acc_c.addr;
          mem_wdata_nxt = cur_acc_c.wdata;
          lock_cnt_nxt  = lock_cnt + LCNT_W'(1);
        end
`endif
      end
      default: begin
        state_nxt     = IDLE;
        mem_w_r_nxt   = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_w_r    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      cur        <= cur_nxt;
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
      busy       <= busy_nxt;
      mem_en     <= mem_en_nxt;
      mem_w_r    <= mem_w_r_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      rdata      <= rdata_nxt;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt   <= lock_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, w_r0, lock0, gnt0, done0;
  logic [4:0] addr0;
  logic [7:0] wdata0;
  logic       req1, w_r1, lock1, gnt1, done1;
  logic [4:0] addr1;
  logic [7:0] wdata1;
  logic [7:0] rdata;
  logic       busy, mem_en, mem_w_r;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [32] = '{default: 8'h00};
  logic [7:0] ref_mem [32] = '{default: 8'h00};
  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .w_r0(w_r0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(gnt0), .done0(done0),
    .req1(req1), .w_r1(w_r1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_w_r(mem_w_r), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_w_r) mem[mem_addr] <= mem_wdata;
      else         mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 0; w_r0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
    req1 = 0; w_r1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
    repeat (2) tick();
    n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0) begin n_bad++; $display("FAIL rst_pulses got %b want 0000", {gnt0, gnt1, done0, done1}); end
    n_cmp++; if ({busy, mem_en, mem_w_r} !== 3'b0) begin n_bad++; $display("FAIL rst_ctl got %b want 000", {busy, mem_en, mem_w_r}); end
    n_cmp++; if ({rdata, mem_addr, mem_wdata} !== 21'b0) begin n_bad++; $display("FAIL rst_data got %h want 0", {rdata, mem_addr, mem_wdata}); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    req0 = 1; w_r0 = 1; addr0 = 5'd5; wdata0 = 8'hA5;
    tick();
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("FAIL wr_gnt got %b%b want 10", gnt0, gnt1); end
    n_cmp++; if (mem_en !== 1'b1 || mem_w_r !== 1'b1) begin n_bad++; $display("FAIL wr_memctl got %b%b want 11", mem_en, mem_w_r); end
    n_cmp++; if (mem_addr !== 5'd5 || mem_wdata !== 8'hA5) begin n_bad++; $display("FAIL wr_membus got %h/%h want 05/a5", mem_addr, mem_wdata); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy1 got %b want 1", busy); end
    tick();
    n_cmp++; if ({gnt0, mem_en, done0, busy} !== 4'b0001) begin n_bad++; $display("FAIL wr_cyc2 got %b want 0001", {gnt0, mem_en, done0, busy}); end
    n_cmp++; if (mem_addr !== 5'd5 || mem_w_r !== 1'b1) begin n_bad++; $display("FAIL wr_hold got %h/%b want 05/1", mem_addr, mem_w_r); end
    tick();
    n_cmp++; if ({done0, done1, busy} !== 3'b100) begin n_bad++; $display("FAIL wr_done got %b want 100", {done0, done1, busy}); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rdata got %h want 00", rdata); end
    ref_mem[5] = 8'hA5;
    req0 = 0;
    tick();
    n_cmp++; if ({gnt0, done0, busy} !== 3'b000) begin n_bad++; $display("FAIL wr_after got %b want 000", {gnt0, done0, busy}); end
  endtask

  task automatic test_read();
    req1 = 1; w_r1 = 0; addr1 = 5'd5; wdata1 = 8'h00;
    tick();
    n_cmp++; if ({gnt0, gnt1, mem_w_r} !== 3'b010) begin n_bad++; $display("FAIL rd_gnt got %b want 010", {gnt0, gnt1, mem_w_r}); end
    tick();
    tick();
    n_cmp++; if ({done0, done1} !== 2'b01) begin n_bad++; $display("FAIL rd_done got %b want 01", {done0, done1}); end
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_data got %h want a5", rdata); end
    req1 = 0;
    tick();
    n_cmp++; if (rdata !== 8'hA5 || done1 !== 1'b0) begin n_bad++; $display("FAIL rd_hold got %h/%b want a5/0", rdata, done1); end
  endtask

  task automatic test_back_to_back();
    logic e_g0, e_g1, e_d0, e_d1;
    pulse_reset();
    req0 = 1; w_r0 = 0; addr0 = 5'd5;
    req1 = 1; w_r1 = 0; addr1 = 5'd7;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e_g0 = (c % 3 == 1) && (((c - 1) / 3) % 2 == 0);
      e_g1 = (c % 3 == 1) && (((c - 1) / 3) % 2 == 1);
      e_d0 = (c % 3 == 0) && (((c / 3) - 1) % 2 == 0);
      e_d1 = (c % 3 == 0) && (((c / 3) - 1) % 2 == 1);
      n_cmp++; if ({gnt0, gnt1} !== {e_g0, e_g1}) begin n_bad++; $display("FAIL b2b_gnt c%0d got %b%b want %b%b", c, gnt0, gnt1, e_g0, e_g1); end
      n_cmp++; if ({done0, done1} !== {e_d0, e_d1}) begin n_bad++; $display("FAIL b2b_done c%0d got %b%b want %b%b", c, done0, done1, e_d0, e_d1); end
      if (e_d0) begin n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL b2b_rd0 c%0d got %h want a5", c, rdata); end end
      if (e_d1) begin n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL b2b_rd1 c%0d got %h want 00", c, rdata); end end
    end
    req0 = 0; req1 = 0;
    tick();
    n_cmp++; if ({gnt0, gnt1, busy} !== 3'b000) begin n_bad++; $display("FAIL b2b_idle got %b want 000", {gnt0, gnt1, busy}); end
  endtask

  task automatic test_reset_mid();
    req0 = 1; w_r0 = 1; addr0 = 5'h1F; wdata0 = 8'h11;
    tick();
    rst = 1'b1; req0 = 0;
    #1;
    n_cmp++; if ({gnt0, mem_en, busy, mem_w_r} !== 4'b0) begin n_bad++; $display("FAIL rmid_ctl got %b want 0000", {gnt0, mem_en, busy, mem_w_r}); end
    n_cmp++; if ({mem_addr, mem_wdata, rdata} !== 21'b0) begin n_bad++; $display("FAIL rmid_data got %h want 0", {mem_addr, mem_wdata, rdata}); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if ({done0, done1, busy} !== 3'b000) begin n_bad++; $display("FAIL rmid_nodone c%0d got %b want 000", c, {done0, done1, busy}); end
    end
    req0 = 1; w_r0 = 1; addr0 = 5'h1F; wdata0 = 8'h3C;
    repeat (3) tick();
    n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL rmid_wr got %b want 1", done0); end
    ref_mem[31] = 8'h3C;
    req0 = 0;
    req1 = 1; w_r1 = 0; addr1 = 5'h1F;
    tick();
    n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_bad++; $display("FAIL rmid_gnt1 got %b want 01", {gnt0, gnt1}); end
    repeat (2) tick();
    n_cmp++; if (done1 !== 1'b1 || rdata !== 8'h3C) begin n_bad++; $display("FAIL rmid_rd got %b/%h want 1/3c", done1, rdata); end
    req1 = 0;
    tick();
  endtask

  task automatic test_lock();
    logic e_g0, e_g1, e_d0;
    pulse_reset();
    req0 = 1; w_r0 = 0; addr0 = 5'd5; lock0 = 1;
    req1 = 1; w_r1 = 0; addr1 = 5'd7; lock1 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
`ifdef DMEM_ARB_LOCK_EN
      e_g0 = (c == 1) || (c == 3) || (c == 5) || (c == 7);
      e_g1 = (c == 10);
      e_d0 = (c == 3) || (c == 5) || (c == 7) || (c == 9);
`else
      e_g0 = (c == 1) || (c == 7);
      e_g1 = (c == 4) || (c == 10);
      e_d0 = (c == 3) || (c == 9);
`endif
      n_cmp++; if ({gnt0, gnt1} !== {e_g0, e_g1}) begin n_bad++; $display("FAIL lock_gnt c%0d got %b%b want %b%b", c, gnt0, gnt1, e_g0, e_g1); end
      n_cmp++; if (done0 !== e_d0) begin n_bad++; $display("FAIL lock_done0 c%0d got %b want %b", c, done0, e_d0); end
    end
    req0 = 0; req1 = 0; lock0 = 0;
    pulse_reset();
  endtask

  task automatic test_random();
    int since = 100;
    int who = 0;
    int last = 1;
    bit granted;
    logic       e_wr;
    logic [4:0] e_addr;
    logic [7:0] e_wd, e_read;
    logic [7:0] e_rd = 8'h00;
    bit d0, d1;
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      granted = 0;
      if (since >= 2 && (req0 || req1)) begin
        who = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
        last = who;
        since = 0;
        granted = 1;
        e_wr   = (who == 1) ? w_r1 : w_r0;
        e_addr = (who == 1) ? addr1 : addr0;
        e_wd   = (who == 1) ? wdata1 : wdata0;
        if (e_wr) ref_mem[e_addr] = e_wd;
        else      e_read = ref_mem[e_addr];
      end else if (since < 100) begin
        since++;
      end
      tick();
      d0 = (since == 2) && (who == 0);
      d1 = (since == 2) && (who == 1);
      if (since == 2 && !e_wr) e_rd = e_read;
      n_cmp++; if ({gnt0, gnt1} !== {granted && who == 0, granted && who == 1}) begin n_bad++; $display("FAIL rnd_gnt c%0d got %b%b want %b%b", c, gnt0, gnt1, granted && who == 0, granted && who == 1); end
      n_cmp++; if ({done0, done1} !== {d0, d1}) begin n_bad++; $display("FAIL rnd_done c%0d got %b%b want %b%b", c, done0, done1, d0, d1); end
      n_cmp++; if ({busy, mem_en} !== {since <= 1, granted}) begin n_bad++; $display("FAIL rnd_ctl c%0d got %b%b want %b%b", c, busy, mem_en, since <= 1, granted); end
      n_cmp++; if (rdata !== e_rd) begin n_bad++; $display("FAIL rnd_rdata c%0d got %h want %h", c, rdata, e_rd); end
      if (since <= 1) begin
        n_cmp++; if (mem_addr !== e_addr || mem_w_r !== e_wr || (e_wr && mem_wdata !== e_wd)) begin n_bad++; $display("FAIL rnd_bus c%0d got %h/%b/%h want %h/%b/%h", c, mem_addr, mem_w_r, mem_wdata, e_addr, e_wr, e_wd); end
      end
      if (req0 && d0) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; w_r0 = 1'($urandom_range(0, 1)); addr0 = 5'($urandom_range(0, 31)); wdata0 = 8'($urandom);
      end
      if (req1 && d1) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; w_r1 = 1'($urandom_range(0, 1)); addr1 = 5'($urandom_range(0, 31)); wdata1 = 8'($urandom);
      end
    end
    req0 = 0; req1 = 0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
